// File: rtl/ser_pkg.sv
// Shared types and constants for the bit serializer.
package ser_pkg;

  localparam int unsigned SER_WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Bit counter width; a 2-bit word still needs one counter bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel-in / serial-out bundle between an upstream word source and the serializer.
interface bit_serializer_if
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WIDTH_DEFAULT
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_done;

  modport master (
    output din, din_valid,
    input  din_ready, ser_out, ser_valid, frame_done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, ser_out, ser_valid, frame_done
  );

endinterface

// File: rtl/bit_serializer_core.sv
// Serializer datapath and two-state FSM behind the interface bundle.
module bit_serializer_core
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH     = SER_WIDTH_DEFAULT,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  bit_serializer_if.slave  bus
);

  localparam int unsigned     CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  ser_state_t       state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    bit_cnt, cnt_nxt;
  logic             ready;
  logic             accept;
  logic             din_ready, ser_out, ser_valid, frame_done;

  // Any encoding other than SHIFT behaves as IDLE.
  assign ready  = (state != SHIFT) || (bit_cnt == LAST);
  assign accept = bus.din_valid && ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    case (state)
      SHIFT: begin
        if (accept) begin
          shreg_nxt = bus.din;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end else if (bit_cnt == LAST) begin
          state_nxt = IDLE;
        end else begin
          if (MSB_FIRST != 0) begin
            shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
          end else begin
            shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
          end
          cnt_nxt = bit_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        if (accept) begin
          shreg_nxt = bus.din;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
    endcase
  end

  // Outputs are gated by reset so the line reads all-zero while reset is held.
  always_comb begin
    din_ready  = 1'b0;
    ser_out    = 1'b0;
    ser_valid  = 1'b0;
    frame_done = 1'b0;
    if (!reset) begin
      din_ready = ready;
      if (state == SHIFT) begin
        ser_valid  = 1'b1;
        ser_out    = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
        frame_done = (bit_cnt == LAST);
      end
    end
  end

  assign bus.din_ready  = din_ready;
  assign bus.ser_out    = ser_out;
  assign bus.ser_valid  = ser_valid;
  assign bus.frame_done = frame_done;

endmodule

// File: rtl/bit_serializer.sv
// Top level: flat ports bundled onto the serializer interface for the core.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH     = SER_WIDTH_DEFAULT,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done
);

  bit_serializer_if #(.WIDTH(WIDTH)) bus ();

  assign bus.din       = din;
  assign bus.din_valid = din_valid;
  assign din_ready     = bus.din_ready;
  assign ser_out       = bus.ser_out;
  assign ser_valid     = bus.ser_valid;
  assign frame_done    = bus.frame_done;

  bit_serializer_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: stimulus queues hand-written serial bit orders, monitors pop on ser_valid.
module tb_bit_serializer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(8)) a_bus ();
  bit_serializer_if #(.WIDTH(8)) b_bus ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_a (
    .clk(clk), .reset(reset), .din(a_bus.din), .din_valid(a_bus.din_valid),
    .din_ready(a_bus.din_ready), .ser_out(a_bus.ser_out),
    .ser_valid(a_bus.ser_valid), .frame_done(a_bus.frame_done)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_b (
    .clk(clk), .reset(reset), .din(b_bus.din), .din_valid(b_bus.din_valid),
    .din_ready(b_bus.din_ready), .ser_out(b_bus.ser_out),
    .ser_valid(b_bus.ser_valid), .frame_done(b_bus.frame_done)
  );

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // seq lists the expected line bits in transmit order, leftmost first.
  task automatic push_seq(input bit to_b, input logic [7:0] seq);
    for (int i = 7; i >= 0; i--) begin
      exp_t e;
      e.b    = seq[i];
      e.last = (i == 0);
      if (to_b) qb.push_back(e);
      else      qa.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (a_bus.ser_valid === 1'b1) begin
      if (qa.size() == 0) begin
        check("a_unexpected_bit", a_bus.ser_valid, 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_ser_out", a_bus.ser_out, e.b);
        check("a_frame_done", a_bus.frame_done, e.last);
      end
    end else begin
      check("a_idle_ser_out", a_bus.ser_out, 0);
      check("a_idle_frame_done", a_bus.frame_done, 0);
    end
  end

  always @(negedge clk) begin
    if (b_bus.ser_valid === 1'b1) begin
      if (qb.size() == 0) begin
        check("b_unexpected_bit", b_bus.ser_valid, 0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("b_ser_out", b_bus.ser_out, e.b);
        check("b_frame_done", b_bus.frame_done, e.last);
      end
    end else begin
      check("b_idle_ser_out", b_bus.ser_out, 0);
      check("b_idle_frame_done", b_bus.frame_done, 0);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    a_bus.din       = '0;
    a_bus.din_valid = 1'b0;
    b_bus.din       = '0;
    b_bus.din_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_a_ready", a_bus.din_ready, 0);
    check("rst_a_valid", a_bus.ser_valid, 0);
    check("rst_a_out", a_bus.ser_out, 0);
    check("rst_a_done", a_bus.frame_done, 0);
    check("rst_b_ready", b_bus.din_ready, 0);
    check("rst_b_valid", b_bus.ser_valid, 0);
    reset = 1'b0;

    // A5 MSB-first on A, 01 LSB-first on B
    @(negedge clk);
    check("t1_a_ready_idle", a_bus.din_ready, 1);
    check("t1_b_ready_idle", b_bus.din_ready, 1);
    a_bus.din = 8'hA5; a_bus.din_valid = 1'b1; push_seq(1'b0, 8'b1010_0101);
    b_bus.din = 8'h01; b_bus.din_valid = 1'b1; push_seq(1'b1, 8'b1000_0000);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) begin
        a_bus.din_valid = 1'b0;
        b_bus.din_valid = 1'b0;
      end
      check("t1_a_ser_valid", a_bus.ser_valid, (c <= 8));
      check("t1_b_ser_valid", b_bus.ser_valid, (c <= 8));
    end

    // F0 then 0F with din_valid held: gapless 16 bits
    check("t3_ready_c0", a_bus.din_ready, 1);
    a_bus.din = 8'hF0; a_bus.din_valid = 1'b1; push_seq(1'b0, 8'b1111_0000);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c <= 15) check("t3_din_ready", a_bus.din_ready, (c == 8));
      check("t3_ser_valid", a_bus.ser_valid, (c <= 16));
      if (c == 8) begin
        a_bus.din = 8'h0F;
        push_seq(1'b0, 8'b0000_1111);
      end
      if (c == 9) a_bus.din_valid = 1'b0;
    end

    // Request arriving mid-word waits for the last-bit cycle
    a_bus.din = 8'h3C; a_bus.din_valid = 1'b1; push_seq(1'b0, 8'b0011_1100);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 1) a_bus.din_valid = 1'b0;
      if (c == 3) begin
        a_bus.din = 8'hC3;
        a_bus.din_valid = 1'b1;
      end
      if (c >= 3 && c <= 8) check("t4_din_ready", a_bus.din_ready, (c == 8));
      if (c == 8) push_seq(1'b0, 8'b1100_0011);
      if (c == 9) a_bus.din_valid = 1'b0;
      check("t4_ser_valid", a_bus.ser_valid, (c <= 16));
    end

    // Asynchronous reset mid-word, then accept on first edge after release
    a_bus.din = 8'hFF; a_bus.din_valid = 1'b1; push_seq(1'b0, 8'b1111_1111);
    @(negedge clk);
    a_bus.din_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_ready", a_bus.din_ready, 0);
    check("t5_rst_valid", a_bus.ser_valid, 0);
    check("t5_rst_out", a_bus.ser_out, 0);
    check("t5_rst_done", a_bus.frame_done, 0);
    qa.delete();
    a_bus.din = 8'h96; a_bus.din_valid = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    push_seq(1'b0, 8'b1001_0110);
    #1;
    check("t5_ready_after_rst", a_bus.din_ready, 1);
    @(posedge clk);
    #1 a_bus.din_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("t5_ser_valid", a_bus.ser_valid, (c <= 8));
    end

    // Idle line for 20 cycles
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("t6_idle_valid", a_bus.ser_valid, 0);
      check("t6_idle_out", a_bus.ser_out, 0);
    end

    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: parallel word width in bits, legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port din, input, WIDTH bits: parallel word to serialize.
REQ-006 SHALL have port din_valid, input, 1 bit: din holds a valid word.
REQ-007 SHALL have port din_ready, output, 1 bit: block accepts din this cycle.
REQ-008 SHALL have port ser_out, output, 1 bit: serial bit stream; feeds the downstream sequence detector's in port.
REQ-009 SHALL have port ser_valid, output, 1 bit: ser_out carries a data bit this cycle.
REQ-010 SHALL have port frame_done, output, 1 bit: high during the last bit of a word.

Function
REQ-011 SHALL implement a two-state FSM: IDLE, SHIFT.
REQ-012 SHALL define accept as din_valid && din_ready, sampled at the rising clk edge.
REQ-013 SHALL drive din_ready = 1 in IDLE, and = 1 in SHIFT only while bit_cnt == WIDTH-1; 0 otherwise.
REQ-014 SHALL, on accept, load din into a WIDTH-bit shift register, clear bit_cnt to 0, and enter or remain in SHIFT.
REQ-015 SHALL present the first bit of an accepted word on ser_out in the cycle after accept (latency 1), then one bit per cycle, WIDTH cycles total.
REQ-016 SHALL order bits per MSB_FIRST; the word is not reordered otherwise.
REQ-017 SHALL increment bit_cnt by 1 each SHIFT cycle, 0..WIDTH-1; width is clog2(WIDTH) bits; bit_cnt never wraps within a word.
REQ-018 SHALL hold ser_valid = 1 throughout SHIFT and 0 in IDLE.
REQ-019 SHALL drive ser_out = 0 whenever ser_valid = 0, so an idle line never produces a spurious 1 downstream.
REQ-020 SHALL assert frame_done combinationally while state == SHIFT and bit_cnt == WIDTH-1, exactly one cycle per word.
REQ-021 SHALL, on the last-bit cycle with accept, reload and stay in SHIFT, giving gapless back-to-back words.
REQ-022 SHALL, on the last-bit cycle without accept, return to IDLE.
REQ-023 SHALL ignore din and din_valid whenever din_ready = 0; an upstream that holds din_valid is served at the next last-bit cycle or in IDLE.
REQ-024 SHALL treat any unreachable state encoding as IDLE.

Reset
REQ-025 SHALL, while reset = 1, force state IDLE, bit_cnt 0 and shift register 0, regardless of clk.
REQ-026 SHALL, under reset, drive din_ready 0, ser_out 0, ser_valid 0 and frame_done 0.
REQ-027 SHALL abort an in-progress word on reset with no completion pulse; the remaining bits are discarded.
REQ-028 SHALL be able to accept a word on the first rising clk edge after reset deasserts.

Structure
REQ-029 SHALL place the FSM state typedef (IDLE, SHIFT) and the default width constant SER_WIDTH_DEFAULT = 8 in a shared package, ser_pkg.
REQ-030 SHALL be a single module; no sub-module is required.
REQ-031 SHALL keep the register next-state logic and the output logic in separate always blocks.

Verification
REQ-032 SHALL cover: WIDTH=8, MSB_FIRST=1, din=8'hA5 accepted at cycle 0 -> ser_out 1,0,1,0,0,1,0,1 in cycles 1-8, ser_valid high 1-8, frame_done high only in cycle 8; chained detector pulses twice.
REQ-033 SHALL cover: MSB_FIRST=0, din=8'h01 -> ser_out 1,0,0,0,0,0,0,0 in cycles 1-8.
REQ-034 SHALL cover: din_valid held with 8'hF0 then 8'h0F -> 16 contiguous ser_valid cycles, bits 11110000 00001111, din_ready high in cycles 0 and 8 only.
REQ-035 SHALL cover: din_valid asserted in cycle 3 of a word -> din_ready 0 and the word is not taken; it is accepted in cycle 8, with no gap.
REQ-036 SHALL cover: reset pulsed asynchronously mid-cycle 4 -> all outputs 0 immediately, no frame_done, and a new word is accepted on the next edge after release.
REQ-037 SHALL cover: idle with din_valid=0 for 20 cycles -> ser_out 0 and ser_valid 0 throughout.
